// File: rtl/odd_even_sort_engine_if.sv
// Handshake and data bundle for odd_even_sort_engine.
//
// Ports (slave = engine side):
//   valid_in     upstream offers an array
//   in_ready     engine can accept an array this edge
//   array_in     packed input, element i at [(i+1)*DATAWIDTH-1 : i*DATAWIDTH]
//   descending   sort order captured with array_in (1 = largest at element 0)
//   array_out    last completed result, same packing as array_in
//   valid_out    array_out holds a result not yet taken downstream
//   out_ready    downstream takes the result
//   busy         a sort is running
//   phases_used  phases executed to produce the current result
interface odd_even_sort_engine_if #(
  parameter int DATAWIDTH   = 8,
  parameter int ARRAYLENGTH = 10
);
  localparam int PHASEW = $clog2(ARRAYLENGTH + 1);

  logic                             valid_in;
  logic                             in_ready;
  logic [DATAWIDTH*ARRAYLENGTH-1:0] array_in;
  logic                             descending;
  logic [DATAWIDTH*ARRAYLENGTH-1:0] array_out;
  logic                             valid_out;
  logic                             out_ready;
  logic                             busy;
  logic [PHASEW-1:0]                phases_used;

  modport master (
    output valid_in, array_in, descending, out_ready,
    input  in_ready, array_out, valid_out, busy, phases_used
  );

  modport slave (
    input  valid_in, array_in, descending, out_ready,
    output in_ready, array_out, valid_out, busy, phases_used
  );
endinterface

// File: rtl/odd_even_sort_engine.sv
// Odd-even transposition sorter: one compare/swap phase per clock.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    odd_even_sort_engine_if slave modport (handshake, data, status)
//
// Parameters:
//   DATAWIDTH    bits per element
//   ARRAYLENGTH  element count (2..64)
//   SIGNED       1 = two's-complement compare, 0 = unsigned
//   EARLY_EXIT   1 = finish after two consecutive swap-free phases
module odd_even_sort_engine #(
  parameter int DATAWIDTH   = 8,
  parameter int ARRAYLENGTH = 10,
  parameter int SIGNED      = 0,
  parameter int EARLY_EXIT  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  odd_even_sort_engine_if.slave  bus
);
  localparam int PHASEW = $clog2(ARRAYLENGTH + 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                                state;
  logic [ARRAYLENGTH-1:0][DATAWIDTH-1:0] work;
  logic [ARRAYLENGTH-1:0][DATAWIDTH-1:0] next_work;
  logic [ARRAYLENGTH-1:0][DATAWIDTH-1:0] array_out_r;
  logic                                  desc_r;
  logic [PHASEW-1:0]                     phase_cnt;
  logic [PHASEW-1:0]                     phases_used_r;
  logic                                  prev_clean;
  logic                                  valid_out_r;
  logic                                  busy_r;
  logic                                  any_swap;
  logic                                  last_phase;
  logic                                  sort_exit;
  logic                                  in_ready_c;
  logic                                  accept;

  // True when the pair (a, b) violates the requested order; equal values
  // never count as a violation, so duplicates keep their positions.
  function automatic logic out_of_order(input logic [DATAWIDTH-1:0] a,
                                        input logic [DATAWIDTH-1:0] b,
                                        input logic                 desc);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return desc ? lt : gt;
  endfunction

  // One phase of the compare/swap network. The low bit of the phase counter
  // selects even pairs (0,1),(2,3).. or odd pairs (1,2),(3,4)..; the pairs
  // in a phase are disjoint, so every swap reads the registered array.
  // An unpaired end element simply has no active pair and passes through.
  always_comb begin
    next_work = work;
    any_swap  = 1'b0;
    for (int i = 0; i < ARRAYLENGTH - 1; i++) begin
      if ((i[0] == phase_cnt[0]) && out_of_order(work[i], work[i+1], desc_r)) begin
        next_work[i]   = work[i+1];
        next_work[i+1] = work[i];
        any_swap       = 1'b1;
      end
    end
  end

  // A swap-free even phase followed by a swap-free odd phase (in either
  // order) proves every adjacent pair is ordered, so the sort can stop.
  // prev_clean is cleared on accept, which enforces the two-phase minimum.
  assign last_phase = (phase_cnt == PHASEW'(ARRAYLENGTH - 1));
  assign sort_exit  = last_phase || ((EARLY_EXIT != 0) && !any_swap && prev_clean);

  // Accept from IDLE, or from DONE in the same edge the result is taken.
  assign in_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept     = bus.valid_in && in_ready_c;

  // Control FSM plus datapath registers. array_out/phases_used are only
  // written on SORT exit so they keep the last result through IDLE and SORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      work          <= '0;
      desc_r        <= 1'b0;
      phase_cnt     <= '0;
      prev_clean    <= 1'b0;
      array_out_r   <= '0;
      phases_used_r <= '0;
      valid_out_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work       <= bus.array_in;
            desc_r     <= bus.descending;
            phase_cnt  <= '0;
            prev_clean <= 1'b0;
            busy_r     <= 1'b1;
            state      <= SORT;
          end
        end
        SORT: begin
          work       <= next_work;
          phase_cnt  <= phase_cnt + 1'b1;
          prev_clean <= !any_swap;
          if (sort_exit) begin
            array_out_r   <= next_work;
            phases_used_r <= phase_cnt + 1'b1;
            valid_out_r   <= 1'b1;
            busy_r        <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_out_r <= 1'b0;
            if (accept) begin
              work       <= bus.array_in;
              desc_r     <= bus.descending;
              phase_cnt  <= '0;
              prev_clean <= 1'b0;
              busy_r     <= 1'b1;
              state      <= SORT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          valid_out_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.array_out   = array_out_r;
  assign bus.valid_out   = valid_out_r;
  assign bus.busy        = busy_r;
  assign bus.phases_used = phases_used_r;
endmodule

// File: tb/tb_odd_even_sort_engine.sv
// Bench for odd_even_sort_engine: three instances share one clock/reset.
//   dut_a: N=4,  unsigned, full-length sort
//   dut_b: N=4,  signed,   early exit      (driven with the same stimulus as dut_a)
//   dut_c: N=10, unsigned, early exit
// Expected results come from a plain insertion sort on compare keys; the
// early-exit phase count comes from counting phases until the array is ordered.
module tb_odd_even_sort_engine;
  localparam int W  = 8;
  localparam int NS = 4;
  localparam int NL = 10;

  typedef logic [W-1:0] elem_q_t [$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  odd_even_sort_engine_if #(.DATAWIDTH(W), .ARRAYLENGTH(NS)) bus_a ();
  odd_even_sort_engine_if #(.DATAWIDTH(W), .ARRAYLENGTH(NS)) bus_b ();
  odd_even_sort_engine_if #(.DATAWIDTH(W), .ARRAYLENGTH(NL)) bus_c ();

  odd_even_sort_engine #(.DATAWIDTH(W), .ARRAYLENGTH(NS), .SIGNED(0), .EARLY_EXIT(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  odd_even_sort_engine #(.DATAWIDTH(W), .ARRAYLENGTH(NS), .SIGNED(1), .EARLY_EXIT(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  odd_even_sort_engine #(.DATAWIDTH(W), .ARRAYLENGTH(NL), .SIGNED(0), .EARLY_EXIT(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Hang guard: every wait below is bounded, this only catches the unexpected.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Ordering key: descending order is ascending order of the negated value.
  function automatic int key_of(input logic [W-1:0] v, input bit sgn, input bit desc);
    int k;
    if (sgn) k = int'($signed(v));
    else     k = int'(v);
    return desc ? -k : k;
  endfunction

  function automatic elem_q_t sort_ref(input elem_q_t vals, input bit sgn, input bit desc);
    elem_q_t      r;
    logic [W-1:0] t;
    int           j;
    r = vals;
    for (int i = 1; i < r.size(); i++) begin
      t = r[i];
      j = i;
      while (j > 0 && key_of(r[j-1], sgn, desc) > key_of(t, sgn, desc)) begin
        r[j] = r[j-1];
        j--;
      end
      r[j] = t;
    end
    return r;
  endfunction

  // With early exit the engine stops two phases after the array first becomes
  // ordered (s = phases needed), capped at the element count.
  function automatic int phases_ref(input elem_q_t vals, input bit sgn, input bit desc,
                                    input bit early);
    int k[$];
    int n;
    int s;
    int t;
    bit ordered;
    n = vals.size();
    if (!early) return n;
    foreach (vals[i]) k.push_back(key_of(vals[i], sgn, desc));
    s = n;
    for (int p = 0; p < n; p++) begin
      ordered = 1'b1;
      for (int i = 0; i < n - 1; i++) if (k[i] > k[i+1]) ordered = 1'b0;
      if (ordered) begin
        s = p;
        break;
      end
      for (int i = p % 2; i < n - 1; i += 2) begin
        if (k[i] > k[i+1]) begin
          t = k[i]; k[i] = k[i+1]; k[i+1] = t;
        end
      end
    end
    return (s + 2 < n) ? s + 2 : n;
  endfunction

  function automatic logic [127:0] pack(input elem_q_t vals);
    logic [127:0] r;
    r = '0;
    foreach (vals[i]) r[i*W +: W] = vals[i];
    return r;
  endfunction

  function automatic elem_q_t rand_q(input int n, input int maxv);
    elem_q_t r;
    for (int i = 0; i < n; i++) r.push_back(W'($urandom_range(0, maxv)));
    return r;
  endfunction

  // Present an array to dut_a/dut_b at a negedge; returns at the negedge after
  // the accepting edge with junk on the inputs and valid_in still high.
  task automatic apply_stimulus_small(input elem_q_t vals, input logic desc);
    logic [127:0] w;
    w = pack(vals);
    bus_a.array_in = w[W*NS-1:0];  bus_b.array_in = w[W*NS-1:0];
    bus_a.descending = desc;       bus_b.descending = desc;
    bus_a.valid_in = 1'b1;         bus_b.valid_in = 1'b1;
    bus_a.out_ready = 1'b1;        bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;        bus_b.out_ready = 1'b0;
    w = {$urandom, $urandom, $urandom, $urandom};
    bus_a.array_in = w[W*NS-1:0];  bus_b.array_in = w[W*NS-1:0];
    bus_a.descending = ~desc;      bus_b.descending = ~desc;
  endtask

  task automatic collect_small(input elem_q_t vals, input logic desc, input int stall,
                               input string tag);
    int lat_a;
    int lat_b;
    int cyc;
    int ph_b;
    ph_b = phases_ref(vals, 1, desc, 1);
    check_output({tag, " busy_a"}, bus_a.busy, 1'b1);
    lat_a = -1; lat_b = -1; cyc = 0;
    while ((lat_a < 0 || lat_b < 0) && cyc < 20) begin
      if (lat_a < 0 && bus_a.valid_out) lat_a = cyc;
      if (lat_b < 0 && bus_b.valid_out) lat_b = cyc;
      if (lat_a < 0 || lat_b < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_output({tag, " latency_a"}, lat_a, NS);
    check_output({tag, " latency_b"}, lat_b, ph_b);
    repeat (stall) @(negedge clk);
    check_output({tag, " valid_a"}, bus_a.valid_out, 1'b1);
    check_output({tag, " valid_b"}, bus_b.valid_out, 1'b1);
    check_output({tag, " in_ready_a"}, bus_a.in_ready, 1'b0);
    check_output({tag, " busy_b"}, bus_b.busy, 1'b0);
    check_output({tag, " array_a"}, bus_a.array_out, pack(sort_ref(vals, 0, desc)));
    check_output({tag, " array_b"}, bus_b.array_out, pack(sort_ref(vals, 1, desc)));
    check_output({tag, " phases_a"}, bus_a.phases_used, NS);
    check_output({tag, " phases_b"}, bus_b.phases_used, ph_b);
    bus_a.valid_in = 1'b0; bus_b.valid_in = 1'b0;
  endtask

  task automatic release_small(input string tag);
    bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
    bus_a.valid_in = 1'b0;  bus_b.valid_in = 1'b0;
    @(negedge clk);
    check_output({tag, " drop_a"}, bus_a.valid_out, 1'b0);
    check_output({tag, " drop_b"}, bus_b.valid_out, 1'b0);
    check_output({tag, " idle_ready_a"}, bus_a.in_ready, 1'b1);
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
  endtask

  task automatic run_small(input elem_q_t vals, input logic desc, input int stall,
                           input string tag);
    apply_stimulus_small(vals, desc);
    collect_small(vals, desc, stall, tag);
    release_small(tag);
  endtask

  task automatic apply_stimulus_big(input elem_q_t vals, input logic desc);
    logic [127:0] w;
    w = pack(vals);
    bus_c.array_in = w[W*NL-1:0];
    bus_c.descending = desc;
    bus_c.valid_in = 1'b1;
    bus_c.out_ready = 1'b1;
    @(negedge clk);
    bus_c.out_ready = 1'b0;
    w = {$urandom, $urandom, $urandom, $urandom};
    bus_c.array_in = w[W*NL-1:0];
    bus_c.descending = ~desc;
  endtask

  task automatic collect_big(input elem_q_t vals, input logic desc, input string tag);
    int lat;
    int cyc;
    int ph;
    ph = phases_ref(vals, 0, desc, 1);
    check_output({tag, " busy"}, bus_c.busy, 1'b1);
    lat = -1; cyc = 0;
    while (lat < 0 && cyc < 30) begin
      if (bus_c.valid_out) lat = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check_output({tag, " latency"}, lat, ph);
    check_output({tag, " array"}, bus_c.array_out, pack(sort_ref(vals, 0, desc)));
    check_output({tag, " phases"}, bus_c.phases_used, ph);
    check_output({tag, " in_ready"}, bus_c.in_ready, 1'b0);
    bus_c.valid_in = 1'b0;
    bus_c.out_ready = 1'b1;
    @(negedge clk);
    check_output({tag, " drop"}, bus_c.valid_out, 1'b0);
    bus_c.out_ready = 1'b0;
  endtask

  task automatic run_big(input elem_q_t vals, input logic desc, input string tag);
    apply_stimulus_big(vals, desc);
    collect_big(vals, desc, tag);
  endtask

  initial begin
    elem_q_t v;
    int      hits;

    bus_a.valid_in = 1'b0; bus_a.array_in = '0; bus_a.descending = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.valid_in = 1'b0; bus_b.array_in = '0; bus_b.descending = 1'b0; bus_b.out_ready = 1'b0;
    bus_c.valid_in = 1'b0; bus_c.array_in = '0; bus_c.descending = 1'b0; bus_c.out_ready = 1'b0;

    // Reset values while rst_n is low
    repeat (2) @(negedge clk);
    check_output("rst valid_a", bus_a.valid_out, 1'b0);
    check_output("rst busy_a", bus_a.busy, 1'b0);
    check_output("rst array_a", bus_a.array_out, '0);
    check_output("rst phases_a", bus_a.phases_used, '0);
    check_output("rst valid_c", bus_c.valid_out, 1'b0);
    check_output("rst array_c", bus_c.array_out, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post-rst in_ready_a", bus_a.in_ready, 1'b1);
    check_output("post-rst in_ready_c", bus_c.in_ready, 1'b1);
    @(negedge clk);

    // [3,1,4,2] both directions, duplicates, presorted, mixed signs
    v = '{8'd3, 8'd1, 8'd4, 8'd2};
    apply_stimulus_small(v, 1'b0);
    collect_small(v, 1'b0, 0, "3142 up");
    check_output("3142 up const", bus_a.array_out, {8'd4, 8'd3, 8'd2, 8'd1});
    release_small("3142 up");
    apply_stimulus_small(v, 1'b1);
    collect_small(v, 1'b1, 0, "3142 dn");
    check_output("3142 dn const", bus_a.array_out, {8'd1, 8'd2, 8'd3, 8'd4});
    release_small("3142 dn");
    v = '{8'd5, 8'd5, 8'd1, 8'd5};
    apply_stimulus_small(v, 1'b0);
    collect_small(v, 1'b0, 0, "dup");
    check_output("dup const", bus_a.array_out, {8'd5, 8'd5, 8'd5, 8'd1});
    release_small("dup");
    v = '{8'd1, 8'd2, 8'd3, 8'd4};
    apply_stimulus_small(v, 1'b0);
    collect_small(v, 1'b0, 0, "presorted");
    check_output("presorted phases const", bus_b.phases_used, 2);
    check_output("presorted array const", bus_b.array_out, {8'd4, 8'd3, 8'd2, 8'd1});
    release_small("presorted");
    v = '{8'h01, 8'hFF, 8'h80, 8'h7F};
    apply_stimulus_small(v, 1'b0);
    collect_small(v, 1'b0, 0, "signmix");
    check_output("signmix unsigned const", bus_a.array_out, {8'hFF, 8'h80, 8'h7F, 8'h01});
    check_output("signmix signed const", bus_b.array_out, {8'h7F, 8'h01, 8'hFF, 8'h80});
    release_small("signmix");

    // Downstream stall for 5 cycles, then back-to-back accept from DONE
    v = '{8'd9, 8'd7, 8'd8, 8'd6};
    apply_stimulus_small(v, 1'b0);
    collect_small(v, 1'b0, 5, "stall");
    v = rand_q(NS, 255);
    apply_stimulus_small(v, 1'b1);
    collect_small(v, 1'b1, 0, "b2b");
    release_small("b2b");

    for (int n = 0; n < 8; n++) begin
      v = rand_q(NS, (n % 2) ? 3 : 255);
      run_small(v, logic'($urandom_range(0, 1)), $urandom_range(0, 3), "rand4");
    end

    // N=10: reversed, presorted, random
    v = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_big(v, 1'b0, "rev10");
    v = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55};
    run_big(v, 1'b0, "sorted10");
    run_big(v, 1'b1, "sorted10 dn");
    for (int n = 0; n < 20; n++) begin
      v = rand_q(NL, (n % 3 == 0) ? 7 : 255);
      run_big(v, logic'($urandom_range(0, 1)), "rand10");
    end

    // Reset pulsed while phase 2 of a 10-element sort is in progress
    v = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    apply_stimulus_big(v, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus_c.valid_in = 1'b0;
    #1;
    check_output("midrst valid", bus_c.valid_out, 1'b0);
    check_output("midrst busy", bus_c.busy, 1'b0);
    check_output("midrst array", bus_c.array_out, '0);
    check_output("midrst phases", bus_c.phases_used, '0);
    check_output("midrst in_ready", bus_c.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus_c.valid_out || bus_c.busy) hits++;
    end
    check_output("midrst no result", hits, 0);
    v = rand_q(NL, 255);
    run_big(v, 1'b1, "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/odd_even_sort_engine.md
ODD_EVEN_SORT_ENGINE -- requirements
Module: odd_even_sort_engine

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, bits per element.
REQ-002 SHALL have parameter ARRAYLENGTH, default 10, element count; legal range 2..64.
REQ-003 SHALL have parameter SIGNED, default 0, 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 SHALL have parameter EARLY_EXIT, default 1, 1 = stop once the array is detected sorted.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port valid_in  input  1  input array valid.
REQ-008 SHALL have port in_ready  output  1  engine can accept an array.
REQ-009 SHALL have port array_in  input  DATAWIDTH*ARRAYLENGTH  element i at bits [(i+1)*DATAWIDTH-1 : i*DATAWIDTH].
REQ-010 SHALL have port descending  input  1  sort order, sampled with array_in; 1 = largest at element 0.
REQ-011 SHALL have port array_out  output  DATAWIDTH*ARRAYLENGTH  sorted result, same packing as array_in.
REQ-012 SHALL have port valid_out  output  1  array_out holds a completed result.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port busy  output  1  sort in progress.
REQ-015 SHALL have port phases_used  output  $clog2(ARRAYLENGTH+1)  number of phases executed for the current result.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, SORT, DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); combinational.
REQ-018 SHALL, on an edge with valid_in && in_ready, capture array_in and descending into internal registers, clear the phase and swap counters, and enter SORT.
REQ-019 SHALL, in SORT, execute exactly one phase per cycle: even phase p compares pairs (0,1),(2,3),...; odd phase compares pairs (1,2),(3,4),...; phase 0 is even.
REQ-020 SHALL swap a pair only on a strict order violation (ascending: a[i] > a[i+1]; descending: a[i] < a[i+1]); equal values are never swapped.
REQ-021 SHALL compare as signed when SIGNED=1, unsigned otherwise.
REQ-022 SHALL, with odd ARRAYLENGTH, leave the unpaired last element unchanged in even phases, and the unpaired element 0 unchanged in odd phases.
REQ-023 SHALL leave SORT after ARRAYLENGTH phases (EARLY_EXIT=0), giving valid_out high ARRAYLENGTH cycles after the accepting edge.
REQ-024 SHALL, when EARLY_EXIT=1, also leave SORT after any two consecutive phases with zero swaps; minimum 2 phases, maximum ARRAYLENGTH.
REQ-025 SHALL load array_out and phases_used on SORT exit, then assert valid_out in DONE.
REQ-026 SHALL hold valid_out, array_out, and phases_used stable in DONE while out_ready=0.
REQ-027 SHALL, in DONE with out_ready=1 and valid_in=0, deassert valid_out next cycle and go IDLE.
REQ-028 SHALL, in DONE with out_ready=1 and valid_in=1, accept the new array on the same edge and go directly to SORT (back-to-back, no idle bubble).
REQ-029 SHALL ignore valid_in, array_in, and descending while in SORT.
REQ-030 SHALL assert busy exactly while state==SORT.
REQ-031 SHALL keep array_out unchanged in IDLE and SORT; array_out retains the last result.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE, valid_out 0, busy 0, array_out 0, phases_used 0, and internal array and counters 0.
REQ-033 SHALL discard an in-flight sort on reset, with no valid_out afterward.
REQ-034 SHALL have in_ready=1 on the first edge after rst_n deasserts.

Verification
REQ-035 SHALL cover: N=4, W=8, EARLY_EXIT=0, elements [3,1,4,2], descending=0 -> valid_out exactly 4 cycles after accept, array_out [1,2,3,4], phases_used=4.
REQ-036 SHALL cover: same input with descending=1 -> [4,3,2,1]; input [5,5,1,5] ascending -> [1,5,5,5].
REQ-037 SHALL cover: EARLY_EXIT=1, presorted [1,2,3,4] ascending -> valid_out 2 cycles after accept, phases_used=2, array unchanged.
REQ-038 SHALL cover: SIGNED=1, elements [8'h01, 8'hFF, 8'h80, 8'h7F] ascending -> [8'h80, 8'hFF, 8'h01, 8'h7F]; SIGNED=0 -> [8'h01, 8'h7F, 8'h80, 8'hFF].
REQ-039 SHALL cover: out_ready=0 for 5 cycles in DONE -> valid_out and array_out stable, in_ready=0; then out_ready=1 with valid_in=1 -> new array accepted on the same edge, busy=1 next cycle.
REQ-040 SHALL cover: rst_n pulsed low at phase 2 of an N=10 sort -> valid_out stays 0, outputs at reset values, next accepted array sorts correctly.
